// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the CPU single-step / free-run clock-enable controller.
package cpu_step_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    FIRE     = 3'd2,
    HELD     = 3'd3,
    RUN      = 3'd4
  } state_t;

  localparam int DB_CYCLES_DEF = 500000;
  localparam int RUN_DIV_DEF   = 5000000;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// 2-FF synchronizer plus a stable-cycle counter; stable rises once the counter
// has run DB_CYCLES cycles since the last clr.
module btn_debounce
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic clr,
  output logic s,
  output logic stable
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          meta;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      s    <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= raw;
      s    <= meta;
      if (clr)
        cnt <= '0;
      else if (cnt != CNT_LAST)
        cnt <= cnt + CW'(1);
    end
  end

  assign stable = (cnt == CNT_LAST);

endmodule

// File: rtl/cpu_step_ctrl.sv
// Single-step / free-run clock-enable generator for a pipelined core.
// Optional macro STEP_AUTOREPEAT_EN adds hold-to-repeat stepping in HELD.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int RUN_DIV   = RUN_DIV_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic             halt,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             running
);

  localparam int DIV_W = $clog2(RUN_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  state_t           state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic             btn_s, run_s;
  logic             db_clr, db_stable;
  logic             run_stable_unused;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
    .clk    (clk),
    .reset  (reset),
    .raw    (step_btn),
    .clr    (db_clr),
    .s      (btn_s),
    .stable (db_stable)
  );

  // The run switch only needs synchronizing; its counter is held cleared.
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run (
    .clk    (clk),
    .reset  (reset),
    .raw    (run_sw),
    .clr    (1'b1),
    .s      (run_s),
    .stable (run_stable_unused)
  );

  always_comb begin
    state_n = state;
    div_n   = '0;
    db_clr  = 1'b1;
    cpu_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (run_s && !halt)
          state_n = RUN;
        else if (btn_s)
          state_n = DEBOUNCE;
      end
      DEBOUNCE: begin
        db_clr = 1'b0;
        if (!btn_s)
          state_n = IDLE;
        else if (db_stable)
          state_n = FIRE;
      end
      FIRE: begin
        cpu_en  = !halt;
        state_n = HELD;
      end
      HELD: begin
        // Any high sample restarts the release count.
        db_clr = btn_s;
        if (!btn_s && db_stable)
          state_n = IDLE;
`ifdef STEP_AUTOREPEAT_EN
        if (btn_s) begin
          div_n  = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
          cpu_en = (div == DIV_LAST) && !halt;
        end
`endif
      end
      RUN: begin
        if (!run_s || halt) begin
          state_n = IDLE;
        end else begin
          div_n  = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
          cpu_en = (div == DIV_LAST);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      div       <= '0;
      cycle_cnt <= '0;
    end else begin
      state <= state_n;
      div   <= div_n;
      if (cpu_en)
        cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed self-checking bench for cpu_step_ctrl (DB_CYCLES=4, RUN_DIV=3, CNT_W=4).
module tb_cpu_step_ctrl;

  localparam int DBC  = 4;
  localparam int RDIV = 3;
  localparam int CW   = 4;

`ifdef STEP_AUTOREPEAT_EN
  localparam int A_PULSES = 3;
  localparam int F_PULSES = 7;
`else
  localparam int A_PULSES = 1;
  localparam int F_PULSES = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          step_btn;
  logic          run_sw;
  logic          halt;
  logic          cpu_en;
  logic [CW-1:0] cycle_cnt;
  logic          running;

  int ncmp  = 0;
  int nfail = 0;
  int pulses;
  int consec;
  int cyc;
  int first_pulse;
  bit prev_en;
  int cnt_exp;

  cpu_step_ctrl #(.DB_CYCLES(DBC), .RUN_DIV(RDIV), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .step_btn  (step_btn),
    .run_sw    (run_sw),
    .halt      (halt),
    .cpu_en    (cpu_en),
    .cycle_cnt (cycle_cnt),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    pulses      = 0;
    consec      = 0;
    cyc         = 0;
    first_pulse = -1;
    prev_en     = 1'b0;
  endtask

  // Sample cpu_en mid-cycle, then advance past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    if (cpu_en === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc;
      if (prev_en) consec++;
    end
    prev_en = (cpu_en === 1'b1);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press();
    step_btn = 1'b1;
    cycles(6);
    step_btn = 1'b0;
    cycles(8);
  endtask

  initial begin
    reset = 1'b1; step_btn = 1'b0; run_sw = 1'b0; halt = 1'b0;
    clr_stats();
    @(posedge clk); @(posedge clk); #1;
    check("rst_running", running, 0);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    reset = 1'b0;
    cycles(3);

    // Bouncing press, then a clean 12-cycle press
    step_btn = 1'b1; cycles(2);
    step_btn = 1'b0; cycles(1);
    step_btn = 1'b1; cycles(2);
    step_btn = 1'b0; cycles(10);
    check("bounce_pulses", pulses, 0);
    check("bounce_cnt", cycle_cnt, 0);
    clr_stats();
    step_btn = 1'b1; cycles(12);
    step_btn = 1'b0; cycles(10);
    check("press_pulses", pulses, A_PULSES);
    check("press_first", first_pulse, 7);
    cnt_exp = A_PULSES;
    check("press_cnt", cycle_cnt, cnt_exp);

    // Free run for 30 cycles
    clr_stats();
    run_sw = 1'b1; cycles(30);
    check("run_pulses", pulses, 9);
    check("run_consec", consec, 0);
    check("run_running", running, 1);
    run_sw = 1'b0; cycles(5);
    check("run_exit_pulses", pulses, 9);
    check("run_exit_running", running, 0);
    cnt_exp = (cnt_exp + 9) % 16;
    check("run_cnt", cycle_cnt, cnt_exp);

    // Halt in RUN on the would-be pulse cycle
    clr_stats();
    run_sw = 1'b1; cycles(5);
    check("haltrun_running", running, 1);
    halt = 1'b1; #1;
    check("haltrun_cpu_en", cpu_en, 0);
    cycles(1);
    check("haltrun_idle", running, 0);
    run_sw = 1'b0; cycles(4);
    halt = 1'b0; cycles(2);
    check("haltrun_pulses", pulses, 0);
    check("haltrun_cnt", cycle_cnt, cnt_exp);

    // Halt during FIRE
    clr_stats();
    step_btn = 1'b1; cycles(7);
    halt = 1'b1; #1;
    check("haltfire_cpu_en", cpu_en, 0);
    cycles(1);
    halt = 1'b0; step_btn = 1'b0; cycles(10);
    check("haltfire_pulses", pulses, 0);
    check("haltfire_cnt", cycle_cnt, cnt_exp);

    // Reset asserted mid-RUN
    run_sw = 1'b1; cycles(6);
    check("rstrun_running", running, 1);
    reset = 1'b1; run_sw = 1'b0; #1;
    check("rstrun_cpu_en", cpu_en, 0);
    check("rstrun_running0", running, 0);
    check("rstrun_cnt", cycle_cnt, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    cycles(3);
    check("rstrun_idle", running, 0);

    // 16 presses wrap the 4-bit counter
    clr_stats();
    for (int p = 0; p < 15; p++) press();
    check("wrap_cnt15", cycle_cnt, 15);
    press();
    check("wrap_cnt0", cycle_cnt, 0);
    check("wrap_pulses", pulses, 16);

    // Button held through reset, then held 20 cycles past FIRE
    clr_stats();
    step_btn = 1'b1; reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    cycles(26);
    step_btn = 1'b0;
    cycles(10);
    check("held_first", first_pulse, 7);
    check("held_pulses", pulses, F_PULSES);
    check("held_consec", consec, 0);
    check("held_cnt", cycle_cnt, F_PULSES);
    check("held_running", running, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
